// File: rtl/led_pkg.sv
// Shared mode codes and seed helper for the LED pattern engine.
// Optional PWM dimming is built only when LED_PWM_EN is defined.
package led_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_UP   = 3'd0;
    localparam logic [MODE_W-1:0] MODE_DOWN = 3'd1;
    localparam logic [MODE_W-1:0] MODE_ROTL = 3'd2;
    localparam logic [MODE_W-1:0] MODE_ROTR = 3'd3;
    localparam logic [MODE_W-1:0] MODE_PING = 3'd4;
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_PING;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Pattern loaded when a mode becomes active; callers truncate to width.
    function automatic logic [31:0] seed(input logic [MODE_W-1:0] mode, input int width);
        case (mode)
            MODE_DOWN:            seed = 32'hFFFF_FFFF >> (32 - width);
            MODE_ROTL, MODE_PING: seed = 32'd1;
            MODE_ROTR:            seed = 32'd1 << (width - 1);
            default:              seed = 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_engine_if.sv
// Step/mode handshake between the LED control block (master) and the
// pattern engine (slave). LED_PWM_EN does not change this interface.
interface led_pattern_engine_if;
    import led_pkg::*;

    logic              en;
    logic              mode_load;
    logic [MODE_W-1:0] mode_sel;
    logic [MODE_W-1:0] mode_cur;
    logic              mode_busy;
    logic              mode_err;

    modport master (
        output en, mode_load, mode_sel,
        input  mode_cur, mode_busy, mode_err
    );

    modport slave (
        input  en, mode_load, mode_sel,
        output mode_cur, mode_busy, mode_err
    );

endinterface

// File: rtl/led_pwm.sv
// Free-running brightness counter and duty compare; instantiated by the
// pattern engine only when LED_PWM_EN is defined.
module led_pwm #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] duty,
    output logic                on
);

    logic [PWM_BITS-1:0] cnt_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p1 <= '0;
        end else begin
            cnt_p1 <= cnt_p1 + PWM_BITS'(1);
        end
    end

    // duty is compared live so brightness changes apply immediately
    assign on = (cnt_p1 < duty);

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern engine: steps a WIDTH-bit pattern once per strobe in one of five
// modes, with a load handshake for mode changes. LED_PWM_EN adds duty dimming.
module led_pattern_engine
    import led_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PWM_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    led_pattern_engine_if.slave  ctrl,
`ifdef LED_PWM_EN
    input  logic [PWM_BITS-1:0]  duty,
`endif
    output logic [WIDTH-1:0]     led,
    output logic                 wrap
);

    if (WIDTH < 2 || PWM_BITS < 1) begin : g_bad_param
        $error("led_pattern_engine: WIDTH must be >= 2 and PWM_BITS >= 1");
    end

    logic [WIDTH-1:0]  pat_p1;
    logic [WIDTH-1:0]  pat_nxt;
    logic [WIDTH-1:0]  seed_val;
    logic [MODE_W-1:0] mode_p1;
    logic [MODE_W-1:0] pend_p1;
    logic              pend_vld_p1;
    logic              dir_p1;
    logic              dir_nxt;
    logic              wrap_p1;
    logic              wrap_nxt;
    logic              err_p1;
    logic              sel_valid;

    assign sel_valid = (ctrl.mode_sel <= MODE_LAST);
    assign seed_val  = WIDTH'(seed(pend_p1, WIDTH));

    // Result of one strobe: either apply the pending mode or step the pattern
    always_comb begin
        pat_nxt  = pat_p1;
        dir_nxt  = dir_p1;
        wrap_nxt = 1'b0;
        if (pend_vld_p1) begin
            pat_nxt = seed_val;
            dir_nxt = DIR_LEFT;
        end else begin
            case (mode_p1)
                MODE_UP: begin
                    pat_nxt  = pat_p1 + WIDTH'(1);
                    wrap_nxt = &pat_p1;
                end
                MODE_DOWN: begin
                    pat_nxt  = pat_p1 - WIDTH'(1);
                    wrap_nxt = ~|pat_p1;
                end
                MODE_ROTL: begin
                    pat_nxt  = {pat_p1[WIDTH-2:0], pat_p1[WIDTH-1]};
                    wrap_nxt = pat_p1[WIDTH-1];
                end
                MODE_ROTR: begin
                    pat_nxt  = {pat_p1[0], pat_p1[WIDTH-1:1]};
                    wrap_nxt = pat_p1[0];
                end
                MODE_PING: begin
                    if (dir_p1 == DIR_LEFT) begin
                        pat_nxt = pat_p1 << 1;
                        if (pat_nxt[WIDTH-1]) dir_nxt = DIR_RIGHT;
                    end else begin
                        pat_nxt = pat_p1 >> 1;
                        if (pat_nxt[0]) begin
                            dir_nxt  = DIR_LEFT;
                            wrap_nxt = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p1: pattern, mode and handshake state
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_p1      <= '0;
            mode_p1     <= MODE_UP;
            pend_vld_p1 <= 1'b0;
            dir_p1      <= DIR_LEFT;
            wrap_p1     <= 1'b0;
            err_p1      <= 1'b0;
        end else begin
            err_p1  <= ctrl.mode_load && !sel_valid;
            wrap_p1 <= ctrl.en && wrap_nxt;
            if (ctrl.en) begin
                pat_p1 <= pat_nxt;
                dir_p1 <= dir_nxt;
                if (pend_vld_p1) mode_p1 <= pend_p1;
            end
            // A load in the same cycle as a strobe stays pending for the next one
            if (ctrl.mode_load && sel_valid) begin
                pend_vld_p1 <= 1'b1;
            end else if (ctrl.en) begin
                pend_vld_p1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ctrl.mode_load && sel_valid) pend_p1 <= ctrl.mode_sel;
    end

    assign ctrl.mode_cur  = mode_p1;
    assign ctrl.mode_busy = pend_vld_p1;
    assign ctrl.mode_err  = err_p1;
    assign wrap           = wrap_p1;

`ifdef LED_PWM_EN
    logic pwm_on;

    led_pwm #(.PWM_BITS(PWM_BITS)) u_pwm (
        .clk  (clk),
        .rst  (rst),
        .duty (duty),
        .on   (pwm_on)
    );

    assign led = pat_p1 & {WIDTH{pwm_on}};
`else
    assign led = pat_p1;
`endif

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed testbench for led_pattern_engine at WIDTH=4; the PWM scenario is
// compiled in when LED_PWM_EN is defined.
`timescale 1ns/1ps
module tb_led_pattern_engine;
    import led_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] led;
    logic       wrap;
    int         tests = 0;
    int         fails = 0;

    led_pattern_engine_if ctrl();

`ifdef LED_PWM_EN
    logic [7:0] duty = 8'd255;
    logic [7:0] cnt_m;
    always @(posedge clk) begin
        if (rst) cnt_m <= 8'd0;
        else     cnt_m <= cnt_m + 8'd1;
    end
`endif

    led_pattern_engine #(.WIDTH(4), .PWM_BITS(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (ctrl),
`ifdef LED_PWM_EN
        .duty (duty),
`endif
        .led  (led),
        .wrap (wrap)
    );

    always #5 clk = ~clk;

    // Expected LED drive for a given pattern register value
    function automatic logic [3:0] exp_led(input logic [3:0] p);
`ifdef LED_PWM_EN
        return p & {4{cnt_m < duty}};
`else
        return p;
`endif
    endfunction

    // Apply inputs at a falling edge; returns at the next falling edge
    task automatic drive(input logic e, input logic l, input logic [2:0] s);
        ctrl.en        = e;
        ctrl.mode_load = l;
        ctrl.mode_sel  = s;
        @(negedge clk);
        ctrl.en        = 1'b0;
        ctrl.mode_load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 3'd2);
        drive(1'b1, 1'b0, 3'd0);
        tests++; if (led !== exp_led(4'h0)) begin fails++; $display("FAIL reset_led: got %h expected %h", led, exp_led(4'h0)); end
        tests++; if (ctrl.mode_cur !== MODE_UP) begin fails++; $display("FAIL reset_mode: got %0d expected 0", ctrl.mode_cur); end
        tests++; if (ctrl.mode_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", ctrl.mode_busy); end
        tests++; if (ctrl.mode_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", ctrl.mode_err); end
        tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
        rst = 1'b0;
    endtask

    task automatic test_up();
        logic [3:0] e;
        for (int i = 1; i <= 17; i++) begin
            drive(1'b1, 1'b0, 3'd0);
            e = 4'(i);
            tests++; if (led !== exp_led(e)) begin fails++; $display("FAIL up_led[%0d]: got %h expected %h", i, led, exp_led(e)); end
            tests++; if (wrap !== (i == 16)) begin fails++; $display("FAIL up_wrap[%0d]: got %b expected %b", i, wrap, (i == 16)); end
        end
    endtask

    task automatic test_rotl();
        logic [3:0] tbl [0:3];
        tbl = '{4'h2, 4'h4, 4'h8, 4'h1};
        drive(1'b0, 1'b1, 3'd2);
        tests++; if (ctrl.mode_busy !== 1'b1) begin fails++; $display("FAIL rotl_busy: got %b expected 1", ctrl.mode_busy); end
        tests++; if (ctrl.mode_cur !== MODE_UP) begin fails++; $display("FAIL rotl_mode_hold: got %0d expected 0", ctrl.mode_cur); end
        tests++; if (led !== exp_led(4'h1)) begin fails++; $display("FAIL rotl_led_hold: got %h expected %h", led, exp_led(4'h1)); end
        drive(1'b1, 1'b0, 3'd0);
        tests++; if (led !== exp_led(4'h1)) begin fails++; $display("FAIL rotl_seed: got %h expected %h", led, exp_led(4'h1)); end
        tests++; if (ctrl.mode_cur !== MODE_ROTL) begin fails++; $display("FAIL rotl_mode: got %0d expected 2", ctrl.mode_cur); end
        tests++; if (ctrl.mode_busy !== 1'b0) begin fails++; $display("FAIL rotl_busy_clr: got %b expected 0", ctrl.mode_busy); end
        tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL rotl_change_wrap: got %b expected 0", wrap); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 3'd0);
            tests++; if (led !== exp_led(tbl[i])) begin fails++; $display("FAIL rotl_led[%0d]: got %h expected %h", i, led, exp_led(tbl[i])); end
            tests++; if (wrap !== (i == 3)) begin fails++; $display("FAIL rotl_wrap[%0d]: got %b expected %b", i, wrap, (i == 3)); end
        end
    endtask

    task automatic test_ping();
        logic [3:0] tbl [0:6];
        tbl = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
        drive(1'b0, 1'b1, 3'd4);
        drive(1'b1, 1'b0, 3'd0);
        tests++; if (led !== exp_led(4'h1)) begin fails++; $display("FAIL ping_seed: got %h expected %h", led, exp_led(4'h1)); end
        tests++; if (ctrl.mode_cur !== MODE_PING) begin fails++; $display("FAIL ping_mode: got %0d expected 4", ctrl.mode_cur); end
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, 3'd0);
            tests++; if (led !== exp_led(tbl[i])) begin fails++; $display("FAIL ping_led[%0d]: got %h expected %h", i, led, exp_led(tbl[i])); end
            tests++; if (wrap !== (i == 5)) begin fails++; $display("FAIL ping_wrap[%0d]: got %b expected %b", i, wrap, (i == 5)); end
        end
    endtask

    task automatic test_err_simul();
        drive(1'b0, 1'b1, 3'd6);
        tests++; if (ctrl.mode_err !== 1'b1) begin fails++; $display("FAIL err_pulse: got %b expected 1", ctrl.mode_err); end
        tests++; if (ctrl.mode_cur !== MODE_PING) begin fails++; $display("FAIL err_mode: got %0d expected 4", ctrl.mode_cur); end
        tests++; if (ctrl.mode_busy !== 1'b0) begin fails++; $display("FAIL err_busy: got %b expected 0", ctrl.mode_busy); end
        drive(1'b0, 1'b0, 3'd0);
        tests++; if (ctrl.mode_err !== 1'b0) begin fails++; $display("FAIL err_one_cycle: got %b expected 0", ctrl.mode_err); end
        tests++; if (led !== exp_led(4'h2)) begin fails++; $display("FAIL err_led: got %h expected %h", led, exp_led(4'h2)); end
        drive(1'b1, 1'b1, 3'd1);
        tests++; if (led !== exp_led(4'h4)) begin fails++; $display("FAIL simul_step: got %h expected %h", led, exp_led(4'h4)); end
        tests++; if (ctrl.mode_cur !== MODE_PING) begin fails++; $display("FAIL simul_mode: got %0d expected 4", ctrl.mode_cur); end
        tests++; if (ctrl.mode_busy !== 1'b1) begin fails++; $display("FAIL simul_busy: got %b expected 1", ctrl.mode_busy); end
        drive(1'b1, 1'b0, 3'd0);
        tests++; if (led !== exp_led(4'hF)) begin fails++; $display("FAIL simul_seed: got %h expected %h", led, exp_led(4'hF)); end
        tests++; if (ctrl.mode_cur !== MODE_DOWN) begin fails++; $display("FAIL simul_newmode: got %0d expected 1", ctrl.mode_cur); end
        tests++; if (ctrl.mode_busy !== 1'b0) begin fails++; $display("FAIL simul_busy_clr: got %b expected 0", ctrl.mode_busy); end
    endtask

    task automatic test_down();
        logic [3:0] e;
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 1'b0, 3'd0);
            e = 4'(15 - i);
            tests++; if (led !== exp_led(e)) begin fails++; $display("FAIL down_led[%0d]: got %h expected %h", i, led, exp_led(e)); end
            tests++; if (wrap !== (i == 16)) begin fails++; $display("FAIL down_wrap[%0d]: got %b expected %b", i, wrap, (i == 16)); end
        end
    endtask

    task automatic test_reset_pending();
        drive(1'b1, 1'b0, 3'd0);
        tests++; if (led !== exp_led(4'hE)) begin fails++; $display("FAIL rp_pre_led: got %h expected %h", led, exp_led(4'hE)); end
        drive(1'b0, 1'b1, 3'd3);
        tests++; if (ctrl.mode_busy !== 1'b1) begin fails++; $display("FAIL rp_busy: got %b expected 1", ctrl.mode_busy); end
        rst = 1'b1;
        drive(1'b1, 1'b0, 3'd0);
        rst = 1'b0;
        tests++; if (led !== exp_led(4'h0)) begin fails++; $display("FAIL rp_led: got %h expected %h", led, exp_led(4'h0)); end
        tests++; if (ctrl.mode_cur !== MODE_UP) begin fails++; $display("FAIL rp_mode: got %0d expected 0", ctrl.mode_cur); end
        tests++; if (ctrl.mode_busy !== 1'b0) begin fails++; $display("FAIL rp_busy_clr: got %b expected 0", ctrl.mode_busy); end
        drive(1'b1, 1'b0, 3'd0);
        tests++; if (led !== exp_led(4'h1)) begin fails++; $display("FAIL rp_step: got %h expected %h", led, exp_led(4'h1)); end
        tests++; if (ctrl.mode_cur !== MODE_UP) begin fails++; $display("FAIL rp_step_mode: got %0d expected 0", ctrl.mode_cur); end
    endtask

    task automatic test_rotr();
        logic [3:0] tbl [0:3];
        tbl = '{4'h4, 4'h2, 4'h1, 4'h8};
        drive(1'b0, 1'b1, 3'd3);
        drive(1'b1, 1'b0, 3'd0);
        tests++; if (led !== exp_led(4'h8)) begin fails++; $display("FAIL rotr_seed: got %h expected %h", led, exp_led(4'h8)); end
        tests++; if (ctrl.mode_cur !== MODE_ROTR) begin fails++; $display("FAIL rotr_mode: got %0d expected 3", ctrl.mode_cur); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 3'd0);
            tests++; if (led !== exp_led(tbl[i])) begin fails++; $display("FAIL rotr_led[%0d]: got %h expected %h", i, led, exp_led(tbl[i])); end
            tests++; if (wrap !== (i == 3)) begin fails++; $display("FAIL rotr_wrap[%0d]: got %b expected %b", i, wrap, (i == 3)); end
        end
    endtask

`ifdef LED_PWM_EN
    task automatic test_pwm();
        logic [7:0] duties [0:2];
        int on_cnt;
        int bad_cnt;
        int span;
        duties = '{8'd0, 8'd128, 8'd255};
        for (int k = 0; k < 3; k++) begin
            duty    = duties[k];
            span    = (duties[k] == 8'd0) ? 512 : 256;
            on_cnt  = 0;
            bad_cnt = 0;
            for (int c = 0; c < span; c++) begin
                @(negedge clk);
                if (led === 4'h8) on_cnt++;
                else if (led !== 4'h0) bad_cnt++;
            end
            tests++; if (on_cnt != int'(duties[k]) * span / 256) begin fails++; $display("FAIL pwm_on[duty=%0d]: got %0d lit cycles expected %0d", duties[k], on_cnt, int'(duties[k]) * span / 256); end
            tests++; if (bad_cnt != 0) begin fails++; $display("FAIL pwm_value[duty=%0d]: got %0d bad cycles expected 0", duties[k], bad_cnt); end
        end
        duty = 8'd255;
    endtask
`endif

    initial begin
        ctrl.en        = 1'b0;
        ctrl.mode_load = 1'b0;
        ctrl.mode_sel  = 3'd0;
        repeat (2) @(negedge clk);
        test_reset();
        test_up();
        test_rotl();
        test_ping();
        test_err_simul();
        test_down();
        test_reset_pending();
        test_rotr();
`ifdef LED_PWM_EN
        test_pwm();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "timeout");
    end

endmodule
